// File: rtl/host_cmd_pkg.sv
// Package: host_cmd_pkg
// Shared constants and types for the host command decoder: command and
// acknowledge bytes, FSM state encoding, register-group codes and the
// register address map used by reg_addr_decode.
package host_cmd_pkg;

   localparam logic [7:0] CMD_WR  = 8'h57;
   localparam logic [7:0] CMD_RD  = 8'h52;
   localparam logic [7:0] ACK_OK  = 8'hAA;
   localparam logic [7:0] ACK_ERR = 8'hEE;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StData,
      StWrite,
      StRead,
      StResp,
      StAck
   } state_e;

   typedef enum logic [2:0] {
      GrpNone,
      GrpVersion,
      GrpGate,
      GrpDac,
      GrpCounter,
      GrpPwm
   } grp_e;

   // Register address map (inclusive ranges)
   localparam logic [7:0] ADDR_VERSION = 8'h00;
   localparam logic [7:0] ADDR_DAC_A0  = 8'h02;
   localparam logic [7:0] ADDR_DAC_A1  = 8'h03;
   localparam logic [7:0] ADDR_DAC_LO  = 8'h23;
   localparam logic [7:0] ADDR_DAC_HI  = 8'h25;
   localparam logic [7:0] ADDR_GATE_LO = 8'h20;
   localparam logic [7:0] ADDR_GATE_HI = 8'h22;
   localparam logic [7:0] ADDR_CNTA_LO = 8'h26;
   localparam logic [7:0] ADDR_CNTA_HI = 8'h29;
   localparam logic [7:0] ADDR_CNTB_LO = 8'h30;
   localparam logic [7:0] ADDR_CNTB_HI = 8'h35;
   localparam logic [7:0] ADDR_PWMA_LO = 8'h36;
   localparam logic [7:0] ADDR_PWMA_HI = 8'h39;
   localparam logic [7:0] ADDR_PWMB_LO = 8'h40;
   localparam logic [7:0] ADDR_PWMB_HI = 8'h46;

endpackage

// File: rtl/reg_addr_decode.sv
// Module: reg_addr_decode
// Combinational register address -> owning group code. Shared with the
// read-back mux so write decode and read-back agree on the map.
// Ports:
//   addr  in  8  register address
//   grp   out 3  group code (host_cmd_pkg::grp_e)
module reg_addr_decode
   import host_cmd_pkg::*;
(
   input  logic [7:0] addr,
   output logic [2:0] grp
);

   grp_e g;

   always_comb begin
      g = GrpNone;
      if (addr == ADDR_VERSION) begin
         g = GrpVersion;
      end else if (addr == ADDR_DAC_A0 || addr == ADDR_DAC_A1 ||
                   (addr >= ADDR_DAC_LO && addr <= ADDR_DAC_HI)) begin
         g = GrpDac;
      end else if (addr >= ADDR_GATE_LO && addr <= ADDR_GATE_HI) begin
         g = GrpGate;
      end else if ((addr >= ADDR_CNTA_LO && addr <= ADDR_CNTA_HI) ||
                   (addr >= ADDR_CNTB_LO && addr <= ADDR_CNTB_HI)) begin
         g = GrpCounter;
      end else if ((addr >= ADDR_PWMA_LO && addr <= ADDR_PWMA_HI) ||
                   (addr >= ADDR_PWMB_LO && addr <= ADDR_PWMB_HI)) begin
         g = GrpPwm;
      end
   end

   assign grp = g;

endmodule

// File: rtl/host_cmd_decoder.sv
// Module: host_cmd_decoder
// Parses host byte frames (write: 57 ADDR DATA, read: 52 ADDR) into one-cycle
// register write strobes and read requests; read data is returned upstream.
// Optional macro HOST_CMD_ACK_EN: each write frame is answered with 0xAA
// (written) or 0xEE (rejected) on the tx side.
// Ports:
//   clk, reset (sync, active-high)
//   rx_data/rx_valid/rx_ready   byte stream from host link
//   tx_data/tx_valid/tx_ready   response byte to host link
//   wr_addr/wr_data             current write, held until the next write
//   wr_gate/wr_dac/wr_counter/wr_pwm  one-cycle write strobes
//   rd_addr/rd_data             read-back mux interface
//   err                         one-cycle error pulse
module host_cmd_decoder
   import host_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter int unsigned TO_W           = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       wr_gate,
   output logic       wr_dac,
   output logic       wr_counter,
   output logic       wr_pwm,
   output logic [7:0] rd_addr,
   input  logic [7:0] rd_data,
   output logic       err
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   state_e          state_q, state_d;
   logic            is_wr_q, is_wr_d;
   logic [7:0]      addr_q, addr_d;
   logic [7:0]      wr_addr_q, wr_addr_d;
   logic [7:0]      wr_data_q, wr_data_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic [3:0]      strobe_q, strobe_d;   // {pwm, counter, dac, gate}
   logic            err_q, err_d;
   logic [TO_W-1:0] to_q, to_d;
   logic [2:0]      grp_raw;
   logic            timeout_hit;

   reg_addr_decode u_decode (
      .addr (addr_q),
      .grp  (grp_raw)
   );

   // Last waiting cycle of a partial frame; no byte is taken on this cycle.
   assign timeout_hit = (state_q == StAddr || state_q == StData) && (to_q == TO_LAST);

   always_comb begin
      state_d   = state_q;
      is_wr_d   = is_wr_q;
      addr_d    = addr_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      tx_data_d = tx_data_q;
      strobe_d  = 4'b0000;
      err_d     = 1'b0;
      to_d      = to_q;
      rx_ready  = 1'b0;
      tx_valid  = 1'b0;

      unique case (state_q)
         StIdle: begin
            rx_ready = 1'b1;
            to_d     = '0;
            if (rx_valid) begin
               if (rx_data == CMD_WR || rx_data == CMD_RD) begin
                  is_wr_d = (rx_data == CMD_WR);
                  state_d = StAddr;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StAddr, StData: begin
            rx_ready = !timeout_hit;
            if (timeout_hit) begin
               state_d = StIdle;
               err_d   = 1'b1;
               to_d    = '0;
            end else if (rx_valid) begin
               to_d = '0;
               if (state_q == StAddr) begin
                  addr_d  = rx_data;
                  state_d = is_wr_q ? StData : StRead;
               end else begin
                  wr_addr_d = addr_q;
                  wr_data_d = rx_data;
                  state_d   = StWrite;
                  unique case (grp_e'(grp_raw))
                     GrpGate:    strobe_d[0] = 1'b1;
                     GrpDac:     strobe_d[1] = 1'b1;
                     GrpCounter: strobe_d[2] = 1'b1;
                     GrpPwm:     strobe_d[3] = 1'b1;
                     default:    err_d       = 1'b1;  // version (RO) or unmapped
                  endcase
`ifdef HOST_CMD_ACK_EN
                  tx_data_d = (grp_e'(grp_raw) inside {GrpGate, GrpDac, GrpCounter, GrpPwm})
                              ? ACK_OK : ACK_ERR;
`endif
               end
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         StWrite: begin
`ifdef HOST_CMD_ACK_EN
            state_d = StAck;
`else
            state_d = StIdle;
`endif
         end
         StRead: begin
            tx_data_d = rd_data;
            state_d   = StResp;
         end
         StResp, StAck: begin
            tx_valid = 1'b1;
            if (tx_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         is_wr_q   <= 1'b0;
         addr_q    <= 8'h00;
         wr_addr_q <= 8'h00;
         wr_data_q <= 8'h00;
         tx_data_q <= 8'h00;
         strobe_q  <= 4'b0000;
         err_q     <= 1'b0;
         to_q      <= '0;
      end else begin
         state_q   <= state_d;
         is_wr_q   <= is_wr_d;
         addr_q    <= addr_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         tx_data_q <= tx_data_d;
         strobe_q  <= strobe_d;
         err_q     <= err_d;
         to_q      <= to_d;
      end
   end

   assign tx_data    = tx_data_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign wr_gate    = strobe_q[0];
   assign wr_dac     = strobe_q[1];
   assign wr_counter = strobe_q[2];
   assign wr_pwm     = strobe_q[3];
   assign rd_addr    = addr_q;
   assign err        = err_q;

endmodule

// File: tb/tb_host_cmd_decoder.sv
module tb_host_cmd_decoder;

   localparam int TO = 40;
`ifdef HOST_CMD_ACK_EN
   localparam bit ACK = 1'b1;
`else
   localparam bit ACK = 1'b0;
`endif
   localparam logic [7:0] VERSION = 8'h13;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
   logic       wr_gate, wr_dac, wr_counter, wr_pwm, err;

   host_cmd_decoder #(.TIMEOUT_CYCLES(TO), .TO_W(16)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_gate(wr_gate), .wr_dac(wr_dac), .wr_counter(wr_counter),
      .wr_pwm(wr_pwm), .rd_addr(rd_addr), .rd_data(rd_data), .err(err)
   );

   always #5 clk = ~clk;

   // Reference register map: one-hot {pwm, counter, dac, gate}
   function automatic logic [3:0] ref_strobe(input logic [7:0] a);
      if (a == 8'h02 || a == 8'h03 || (a >= 8'h23 && a <= 8'h25)) return 4'b0010;
      if (a >= 8'h20 && a <= 8'h22) return 4'b0001;
      if ((a >= 8'h26 && a <= 8'h29) || (a >= 8'h30 && a <= 8'h35)) return 4'b0100;
      if ((a >= 8'h36 && a <= 8'h39) || (a >= 8'h40 && a <= 8'h46)) return 4'b1000;
      return 4'b0000;
   endfunction

   // Read-back mux model: version byte, mapped regs give addr^0x83, unmapped 0
   function automatic logic [7:0] ref_mux(input logic [7:0] a);
      if (a == 8'h00) return VERSION;
      if (ref_strobe(a) != 4'b0000) return a ^ 8'h83;
      return 8'h00;
   endfunction

   assign rd_data = ref_mux(rd_addr);

   typedef struct {
      logic [7:0] cmd, addr, data;
      logic [3:0] stb;
      logic       err;
      logic       txen;
      logic [7:0] tx;
   } vec_t;

   function automatic vec_t mk(input logic [7:0] c, a, d, input logic [3:0] s,
                               input logic e, input logic te, input logic [7:0] t);
      vec_t v;
      v.cmd = c; v.addr = a; v.data = d; v.stb = s; v.err = e; v.txen = te; v.tx = t;
      return v;
   endfunction

   // Higher-level model: outcome of one frame from the frame rules alone
   function automatic vec_t model(input logic [7:0] c, a, d);
      logic [3:0] s;
      if (c == 8'h57) begin
         s = ref_strobe(a);
         return mk(c, a, d, s, s == 4'b0000, ACK, (s != 4'b0000) ? 8'hAA : 8'hEE);
      end
      if (c == 8'h52) return mk(c, a, d, 4'b0000, 1'b0, 1'b1, ref_mux(a));
      return mk(c, a, d, 4'b0000, 1'b1, 1'b0, 8'h00);
   endfunction

   // Event monitor, sampled on the falling edge
   int n_gate = 0, n_dac = 0, n_cnt = 0, n_pwm = 0, n_err = 0, n_tx = 0, n_txv = 0;
   logic [7:0] last_wa = 8'h00, last_wd = 8'h00, last_tx = 8'h00;

   always @(negedge clk) begin
      if (!reset) begin
         if (wr_gate)    n_gate <= n_gate + 1;
         if (wr_dac)     n_dac  <= n_dac + 1;
         if (wr_counter) n_cnt  <= n_cnt + 1;
         if (wr_pwm)     n_pwm  <= n_pwm + 1;
         if (wr_gate | wr_dac | wr_counter | wr_pwm) begin
            last_wa <= wr_addr;
            last_wd <= wr_data;
         end
         if (err)      n_err <= n_err + 1;
         if (tx_valid) n_txv <= n_txv + 1;
         if (tx_valid && tx_ready) begin
            n_tx    <= n_tx + 1;
            last_tx <= tx_data;
         end
      end
   end

   int nvec = 0, nmis = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t;
      t = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      while (!rx_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!rx_ready) begin
         check("rx_ready_wait", 32'd0, 32'd1);
         @(posedge clk);
      end else begin
         @(posedge clk);
      end
      #1;
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   task automatic run_frame(input string tag, input vec_t v, input int gap, input int txd);
      int s_gate, s_dac, s_cnt, s_pwm, s_err, s_tx, s_txv, t;
      s_gate = n_gate; s_dac = n_dac; s_cnt = n_cnt; s_pwm = n_pwm;
      s_err = n_err; s_tx = n_tx; s_txv = n_txv;
      send_byte(v.cmd);
      if (v.cmd == 8'h57 || v.cmd == 8'h52) begin
         idle(gap);
         send_byte(v.addr);
         if (v.cmd == 8'h57) begin
            idle(gap);
            send_byte(v.data);
         end
      end
      if (v.txen) begin
         t = 0;
         @(negedge clk);
         while (!tx_valid && t < 20) begin
            @(negedge clk);
            t++;
         end
         if (!tx_valid) begin
            check({tag, " tx_valid_wait"}, 32'd0, 32'd1);
         end else begin
            repeat (txd) @(negedge clk);
            @(posedge clk);
            #1 tx_ready = 1'b1;
            @(posedge clk);
            #1 tx_ready = 1'b0;
         end
      end else begin
         idle(3);
      end
      idle(2);
      check({tag, " strobes"},
            {8'(n_pwm - s_pwm), 8'(n_cnt - s_cnt), 8'(n_dac - s_dac), 8'(n_gate - s_gate)},
            {8'(v.stb[3]), 8'(v.stb[2]), 8'(v.stb[1]), 8'(v.stb[0])});
      check({tag, " err"}, 32'(n_err - s_err), 32'(v.err));
      if (v.stb != 4'b0000) check({tag, " wr_addr/data"}, {last_wa, last_wd}, {v.addr, v.data});
      check({tag, " tx_count"}, 32'(n_tx - s_tx), 32'(v.txen));
      if (v.txen) check({tag, " tx_data"}, 32'(last_tx), 32'(v.tx));
      else        check({tag, " tx_valid_cycles"}, 32'(n_txv - s_txv), 32'd0);
   endtask

   vec_t tbl[$];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int cnt, s_err, s_stb;
      logic [7:0] c, a;

      tbl.push_back(mk(8'h57, 8'h21, 8'h5A, 4'b0001, 1'b0, ACK, 8'hAA));
      tbl.push_back(mk(8'h57, 8'h2B, 8'h11, 4'b0000, 1'b1, ACK, 8'hEE));
      tbl.push_back(mk(8'h57, 8'h00, 8'h11, 4'b0000, 1'b1, ACK, 8'hEE));
      tbl.push_back(mk(8'h52, 8'h40, 8'h00, 4'b0000, 1'b0, 1'b1, 8'hC3));
      tbl.push_back(mk(8'h41, 8'h00, 8'h00, 4'b0000, 1'b1, 1'b0, 8'h00));
      tbl.push_back(mk(8'h57, 8'h03, 8'h7F, 4'b0010, 1'b0, ACK, 8'hAA));
      tbl.push_back(mk(8'h52, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b1, VERSION));
      tbl.push_back(mk(8'h52, 8'h2C, 8'h00, 4'b0000, 1'b0, 1'b1, 8'h00));
      tbl.push_back(mk(8'h57, 8'h46, 8'h99, 4'b1000, 1'b0, ACK, 8'hAA));
      tbl.push_back(mk(8'h57, 8'h47, 8'h01, 4'b0000, 1'b1, ACK, 8'hEE));
      tbl.push_back(mk(8'h57, 8'h30, 8'h55, 4'b0100, 1'b0, ACK, 8'hAA));
      tbl.push_back(mk(8'h57, 8'h29, 8'h66, 4'b0100, 1'b0, ACK, 8'hAA));
      tbl.push_back(mk(8'h57, 8'h2F, 8'h01, 4'b0000, 1'b1, ACK, 8'hEE));
      tbl.push_back(mk(8'h57, 8'h3A, 8'h02, 4'b0000, 1'b1, ACK, 8'hEE));
      tbl.push_back(mk(8'h57, 8'h20, 8'h00, 4'b0001, 1'b0, ACK, 8'hAA));
      tbl.push_back(mk(8'h57, 8'h25, 8'hFF, 4'b0010, 1'b0, ACK, 8'hAA));
      tbl.push_back(mk(8'h57, 8'h39, 8'h3C, 4'b1000, 1'b0, ACK, 8'hAA));
      tbl.push_back(mk(8'h57, 8'h01, 8'h10, 4'b0000, 1'b1, ACK, 8'hEE));
      tbl.push_back(mk(8'h52, 8'h24, 8'h00, 4'b0000, 1'b0, 1'b1, 8'hA7));
      tbl.push_back(mk(8'hFF, 8'h00, 8'h00, 4'b0000, 1'b1, 1'b0, 8'h00));

      reset = 1'b1; rx_valid = 1'b1; rx_data = 8'h57; tx_ready = 1'b0;
      idle(3);
      rx_valid = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      check("reset_state",
            {rx_ready, tx_valid, err, wr_gate, wr_dac, wr_counter, wr_pwm, tx_data, wr_addr,
             wr_data},
            {1'b1, 1'b0, 1'b0, 4'b0000, 8'h00, 8'h00, 8'h00});
      check("reset_rd_addr", 32'(rd_addr), 32'd0);
      idle(1);

      // Directed table
      for (int i = 0; i < tbl.size(); i++) begin
         run_frame($sformatf("tbl%0d", i), tbl[i], i % 3, i % 4);
      end

      // Read response held while link stalls; rx stalled throughout
      send_byte(8'h52);
      send_byte(8'h40);
      cnt = 0;
      @(negedge clk);
      while (!tx_valid && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      check("hold rd_addr", 32'(rd_addr), 32'h40);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("hold cyc%0d", k), {tx_valid, rx_ready, tx_data}, {1'b1, 1'b0, 8'hC3});
         @(negedge clk);
      end
      @(posedge clk);
      #1 tx_ready = 1'b1;
      @(posedge clk);
      #1 tx_ready = 1'b0;
      @(negedge clk);
      check("hold release", {tx_valid, rx_ready}, {1'b0, 1'b1});
      idle(1);

      // Timeout on a partial write frame
      s_err = n_err;
      s_stb = n_gate + n_dac + n_cnt + n_pwm;
      send_byte(8'h57);
      send_byte(8'h24);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!err && cnt < TO + 10);
      check("timeout cycle", 32'(cnt), 32'(TO + 1));
      idle(2);
      check("timeout err count", 32'(n_err - s_err), 32'd1);
      check("timeout no strobe", 32'(n_gate + n_dac + n_cnt + n_pwm - s_stb), 32'd0);
      @(negedge clk);
      check("timeout rx_ready", 32'(rx_ready), 32'd1);
      idle(1);
      run_frame("after_timeout", model(8'h52, 8'h00, 8'h00), 0, 1);

      // Reset in the middle of a write frame
      s_stb = n_gate + n_dac + n_cnt + n_pwm;
      send_byte(8'h57);
      send_byte(8'h36);
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      @(negedge clk);
      check("midreset state", {rx_ready, tx_valid, err, wr_addr, wr_data, tx_data},
            {1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00});
      idle(3);
      check("midreset no strobe", 32'(n_gate + n_dac + n_cnt + n_pwm - s_stb), 32'd0);
      run_frame("after_reset", mk(8'h57, 8'h36, 8'h80, 4'b1000, 1'b0, ACK, 8'hAA), 0, 0);

      // Randomized frames against the model
      for (int i = 0; i < 150; i++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r < 4)      c = 8'h57;
         else if (r < 8) c = 8'h52;
         else            c = 8'($urandom);
         a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 8'h4F)) : 8'($urandom);
         v = model(c, a, 8'($urandom));
         run_frame($sformatf("rnd%0d", i), v, int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
